// File: rtl/iddmm_sched.sv
// iddmm_sched - round-robin scheduler sharing one iddmm_top Montgomery engine
// between R clients.
//
// A job: arbitrate among cli_req, stream the winner's x/y/m operand words into
// the engine write port (N words, addr 0..N-1), raise eng_task_req until the
// engine grants, forward the N result words back to the winner, pulse done.
//
// Optional feature macro: IDDMM_SCHED_TIMEOUT_EN
//   Defined  : watchdog over REQ+RES; after TMO cycles the job is aborted with
//              a 1-cycle cli_err pulse and the scheduler returns to IDLE.
//   Undefined: no watchdog, cli_err tied to 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cli_req   [R]       per-client job request (level)
//   cli_gnt   [R]       one-hot grant, held for the whole job
//   cli_addr  [ADDR_W]  operand word index the granted client presents
//   cli_x/y/m [R*K]     per-client operand words at cli_addr (client i at [i*K +: K])
//   cli_m1    [R*K]     per-client Montgomery constant
//   cli_res   [K]       result word
//   cli_res_vld [R]     result word valid (granted client only)
//   cli_done  [R]       1-cycle job-complete pulse
//   cli_err   [R]       1-cycle abort pulse (watchdog build only)
//   eng_wr_*            engine operand write port
//   eng_task_req/grant  engine task handshake
//   eng_task_end/res    engine result word stream
//   busy                scheduler not idle
module iddmm_sched #(
  parameter int unsigned K      = 128,
  parameter int unsigned N      = 32,
  parameter int unsigned R      = 4,
  parameter int unsigned ADDR_W = $clog2(N),
  parameter int unsigned RID_W  = $clog2(R),
  parameter int unsigned TMO    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [R-1:0]      cli_req,
  output logic [R-1:0]      cli_gnt,
  output logic [ADDR_W-1:0] cli_addr,
  input  logic [R*K-1:0]    cli_x,
  input  logic [R*K-1:0]    cli_y,
  input  logic [R*K-1:0]    cli_m,
  input  logic [R*K-1:0]    cli_m1,
  output logic [K-1:0]      cli_res,
  output logic [R-1:0]      cli_res_vld,
  output logic [R-1:0]      cli_done,
  output logic [R-1:0]      cli_err,
  output logic [2:0]        eng_wr_ena,
  output logic [ADDR_W-1:0] eng_wr_addr,
  output logic [K-1:0]      eng_wr_x,
  output logic [K-1:0]      eng_wr_y,
  output logic [K-1:0]      eng_wr_m,
  output logic [K-1:0]      eng_wr_m1,
  output logic              eng_task_req,
  input  logic              eng_task_grant,
  input  logic              eng_task_end,
  input  logic [K-1:0]      eng_task_res,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_RES,
    S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [RID_W-1:0]   ptr;
  logic [RID_W-1:0]   g;
  logic [R-1:0]       g_oh;
  logic [ADDR_W-1:0]  wc;
  logic [ADDR_W-1:0]  rc;
  logic               arb_hit;
  logic [RID_W-1:0]   arb_idx;
  logic [RID_W-1:0]   cand;
  logic               task_acc;
  logic               job_end;
  logic               wd_expire;

  logic [K-1:0] x_w  [R];
  logic [K-1:0] y_w  [R];
  logic [K-1:0] m_w  [R];
  logic [K-1:0] m1_w [R];

  for (genvar i = 0; i < R; i++) begin : g_split
    assign x_w[i]  = cli_x[i*K +: K];
    assign y_w[i]  = cli_y[i*K +: K];
    assign m_w[i]  = cli_m[i*K +: K];
    assign m1_w[i] = cli_m1[i*K +: K];
  end

  assign g_oh = R'(1) << g;

  // Round-robin search starting at ptr.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < R; i++) begin
      cand = RID_W'((32'(ptr) + i) % R);
      if (!arb_hit && cli_req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // The request is raised only once the last operand write has left the
  // write-port register, so the engine sees addr N-1 before the task request.
  assign task_acc = (state == S_REQ) && eng_task_req && eng_task_grant;

`ifdef IDDMM_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TMO + 1);
  logic [WD_W-1:0] wd;

  assign wd_expire = ((state == S_REQ) || (state == S_RES)) && (wd == WD_W'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd      <= '0;
      cli_err <= '0;
    end else begin
      cli_err <= wd_expire ? g_oh : '0;
      if (state == S_LOAD)
        wd <= '0;
      else if ((state == S_REQ) || (state == S_RES))
        wd <= wd + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO;
  assign wd_expire  = 1'b0;
  assign cli_err    = '0;
`endif

  assign job_end = (state == S_DONE) || wd_expire;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (arb_hit) state_nx = S_LOAD;
      S_LOAD: if (wc == ADDR_W'(N - 1)) state_nx = S_REQ;
      S_REQ:  if (task_acc) state_nx = S_RES;
      S_RES:  if (eng_task_end && (rc == ADDR_W'(N - 1))) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (wd_expire) state_nx = S_IDLE;
  end

  // Combinational outputs
  always_comb begin
    busy         = (state != S_IDLE);
    cli_gnt      = busy ? g_oh : '0;
    cli_done     = (state == S_DONE) ? g_oh : '0;
    eng_task_req = (state == S_REQ) && (eng_wr_ena == 3'b000);
    eng_wr_m1    = busy ? m1_w[g] : '0;
    cli_addr     = wc;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      g           <= '0;
      wc          <= '0;
      rc          <= '0;
      eng_wr_ena  <= '0;
      eng_wr_addr <= '0;
      eng_wr_x    <= '0;
      eng_wr_y    <= '0;
      eng_wr_m    <= '0;
      cli_res     <= '0;
      cli_res_vld <= '0;
    end else begin
      eng_wr_ena  <= '0;
      cli_res_vld <= '0;

      if ((state == S_IDLE) && arb_hit) begin
        g  <= arb_idx;
        wc <= '0;
      end

      if (state == S_LOAD) begin
        eng_wr_ena  <= 3'b111;
        eng_wr_addr <= wc;
        eng_wr_x    <= x_w[g];
        eng_wr_y    <= y_w[g];
        eng_wr_m    <= m_w[g];
        wc          <= (wc == ADDR_W'(N - 1)) ? '0 : wc + 1'b1;
      end

      if (task_acc)
        rc <= '0;

      if ((state == S_RES) && eng_task_end) begin
        cli_res     <= eng_task_res;
        cli_res_vld <= g_oh;
        rc          <= (rc == ADDR_W'(N - 1)) ? '0 : rc + 1'b1;
      end

      if (job_end)
        ptr <= (g == RID_W'(R - 1)) ? '0 : g + 1'b1;
    end
  end

endmodule

// File: tb/tb_iddmm_sched.sv
module tb_iddmm_sched;

  localparam int unsigned K      = 16;
  localparam int unsigned N      = 4;
  localparam int unsigned R      = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned RID_W  = 2;
  localparam int unsigned TMO    = 16;
`ifdef IDDMM_SCHED_TIMEOUT_EN
  localparam int GDLY = 8;
`else
  localparam int GDLY = 10;
`endif

  logic              clk;
  logic              rst;
  logic [R-1:0]      cli_req;
  logic [R-1:0]      cli_gnt;
  logic [ADDR_W-1:0] cli_addr;
  logic [R*K-1:0]    cli_x, cli_y, cli_m, cli_m1;
  logic [K-1:0]      cli_res;
  logic [R-1:0]      cli_res_vld, cli_done, cli_err;
  logic [2:0]        eng_wr_ena;
  logic [ADDR_W-1:0] eng_wr_addr;
  logic [K-1:0]      eng_wr_x, eng_wr_y, eng_wr_m, eng_wr_m1;
  logic              eng_task_req, eng_task_grant, eng_task_end;
  logic [K-1:0]      eng_task_res;
  logic              busy;

  int total = 0;
  int bad = 0;
  int multi_gnt = 0;

  iddmm_sched #(
    .K(K), .N(N), .R(R), .ADDR_W(ADDR_W), .RID_W(RID_W), .TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cli_req(cli_req), .cli_gnt(cli_gnt), .cli_addr(cli_addr),
    .cli_x(cli_x), .cli_y(cli_y), .cli_m(cli_m), .cli_m1(cli_m1),
    .cli_res(cli_res), .cli_res_vld(cli_res_vld), .cli_done(cli_done), .cli_err(cli_err),
    .eng_wr_ena(eng_wr_ena), .eng_wr_addr(eng_wr_addr),
    .eng_wr_x(eng_wr_x), .eng_wr_y(eng_wr_y), .eng_wr_m(eng_wr_m), .eng_wr_m1(eng_wr_m1),
    .eng_task_req(eng_task_req), .eng_task_grant(eng_task_grant),
    .eng_task_end(eng_task_end), .eng_task_res(eng_task_res),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Client operand words: client 1 x words are 0x1..0x4.
  function automatic logic [K-1:0] fx(input int c, input int w);
    return K'(((c + 3) % 4) * 4096 + w + 1);
  endfunction
  function automatic logic [K-1:0] fy(input int c, input int w);
    return K'(c * 256 + 16 + w);
  endfunction
  function automatic logic [K-1:0] fm(input int c, input int w);
    return K'(c * 256 + 32 + w);
  endfunction
  function automatic logic [K-1:0] fm1(input int c);
    return K'(48 + c);
  endfunction

  always_comb begin
    cli_x  = '0;
    cli_y  = '0;
    cli_m  = '0;
    cli_m1 = '0;
    for (int c = 0; c < R; c++) begin
      cli_x[c*K +: K]  = fx(c, int'(cli_addr));
      cli_y[c*K +: K]  = fy(c, int'(cli_addr));
      cli_m[c*K +: K]  = fm(c, int'(cli_addr));
      cli_m1[c*K +: K] = fm1(c);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!$onehot0(cli_gnt)) multi_gnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete job for client c, starting from an IDLE cycle in which c wins.
  task automatic job(input int c, input int gdly, input bit gapped, input logic [R-1:0] req_after);
    logic [R-1:0] oh;
    bit pat[$];
    int k;
    oh = R'(1) << c;
    step();
    cli_req = req_after;
    chk("load_gnt", cli_gnt, oh);
    chk("load_busy", busy, 1);
    chk("load_addr0", cli_addr, 0);
    chk("load_m1", eng_wr_m1, fm1(c));
    chk("load_ena_first", eng_wr_ena, 0);
    for (int w = 0; w < N; w++) begin
      step();
      chk("wr_ena", eng_wr_ena, 3'b111);
      chk("wr_addr", eng_wr_addr, w);
      chk("wr_x", eng_wr_x, fx(c, w));
      chk("wr_y", eng_wr_y, fy(c, w));
      chk("wr_m", eng_wr_m, fm(c, w));
      chk("req_in_load", eng_task_req, 0);
    end
    step();
    chk("req_rise", eng_task_req, 1);
    chk("ena_off", eng_wr_ena, 0);
    for (int d = 0; d < gdly; d++) begin
      eng_task_end = 1'b1;
      eng_task_res = K'(16'hFF);
      step();
      chk("req_hold", eng_task_req, 1);
      chk("vld_in_req", cli_res_vld, 0);
    end
    eng_task_end   = 1'b0;
    eng_task_grant = 1'b1;
    step();
    eng_task_grant = 1'b0;
    chk("req_drop", eng_task_req, 0);
    chk("res_busy", busy, 1);
    if (gapped) pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    else        pat = '{1'b1, 1'b1, 1'b1, 1'b1};
    k = 0;
    foreach (pat[p]) begin
      eng_task_end = pat[p];
      eng_task_res = K'(16'hA0 + k);
      step();
      if (pat[p]) begin
        chk("res_vld", cli_res_vld, oh);
        chk("res_word", cli_res, 32'hA0 + k);
        k++;
      end else begin
        chk("res_gap", cli_res_vld, 0);
      end
      chk("done", cli_done, (k == N) ? oh : '0);
    end
    eng_task_end = 1'b0;
    step();
    chk("end_gnt", cli_gnt, 0);
    chk("end_busy", busy, 0);
    chk("end_done", cli_done, 0);
    chk("end_vld", cli_res_vld, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    cli_req        = '0;
    eng_task_grant = 1'b0;
    eng_task_end   = 1'b0;
    eng_task_res   = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", cli_gnt, 0);
    chk("rst_ena", eng_wr_ena, 0);
    chk("rst_req", eng_task_req, 0);
    chk("rst_vld", cli_res_vld, 0);
    chk("rst_done", cli_done, 0);
    chk("rst_err", cli_err, 0);
    chk("rst_addr", cli_addr, 0);
    chk("rst_m1", eng_wr_m1, 0);
    chk("rst_res", cli_res, 0);
    rst = 1'b0;

    // Single client 1; request dropped right after grant, job still completes.
    cli_req = 4'b0010;
    chk("idle_busy", busy, 0);
    job(1, 0, 1'b0, 4'b0000);

    // Client 2 granted (ptr=2), reset during LOAD word 2.
    cli_req = 4'b0100;
    step();
    chk("c2_gnt", cli_gnt, 4'b0100);
    step();
    step();
    chk("c2_addr2", cli_addr, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", cli_gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ena", eng_wr_ena, 0);
    chk("arst_addr", cli_addr, 0);
    chk("arst_m1", eng_wr_m1, 0);
    chk("arst_done", cli_done, 0);
    cli_req = '0;
    step();
    rst = 1'b0;

    // All requesting: rotation 0,1,2,3,0 with delayed grant and gapped results.
    cli_req = 4'b1111;
    job(0, 0, 1'b0, 4'b1111);
    job(1, GDLY, 1'b0, 4'b1111);
    job(2, 0, 1'b1, 4'b1111);
    job(3, 0, 1'b0, 4'b1111);
    job(0, 0, 1'b0, 4'b0000);
    chk("gnt_onehot", multi_gnt, 0);

`ifdef IDDMM_SCHED_TIMEOUT_EN
    // ptr=1: client 1 wins, engine never grants.
    cli_req = 4'b0011;
    step();
    chk("to_gnt", cli_gnt, 4'b0010);
    repeat (N) step();
    chk("to_last_wr", eng_wr_addr, N - 1);
    for (int t = 1; t < TMO; t++) begin
      step();
      chk("to_no_err", cli_err, 0);
      chk("to_busy", busy, 1);
    end
    step();
    chk("to_err", cli_err, 4'b0010);
    chk("to_done", cli_done, 0);
    chk("to_idle", busy, 0);
    chk("to_req_off", eng_task_req, 0);
    step();
    chk("to_err_pulse", cli_err, 0);
    chk("to_next_gnt", cli_gnt, 4'b0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iddmm_sched.md
Name: iddmm_sched

Overview:
- Round-robin scheduler sharing one iddmm_top Montgomery engine between R requesters.
- Per job: arbitrates; streams the winner's x/y/m operand words into the engine's write port; raises the engine task request; forwards the N result words back to the winner; signals completion.
- Sits between the Paillier modexp controllers (clients) and the single iddmm_top instance.

Parameters:
- K, 128, bits per operand word.
- N, 32, words per operand.
- R, 4, number of clients (>=2).
- ADDR_W, $clog2(N), word address width.
- RID_W, $clog2(R), client index width.
- TMO, 4096, watchdog cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cli_req  in  R  per-client job request, level.
- cli_gnt  out  R  one-hot grant, held for the whole job.
- cli_addr  out  ADDR_W  word index the granted client must present this cycle.
- cli_x / cli_y / cli_m  in  R*K each  per-client operand word at cli_addr, combinational; client i occupies bits [i*K +: K].
- cli_m1  in  R*K  per-client Montgomery constant, stable while granted.
- cli_res  out  K  result word.
- cli_res_vld  out  R  result word valid, granted client only.
- cli_done  out  R  1-cycle job-complete pulse.
- cli_err  out  R  1-cycle abort pulse (optional feature only, else tied 0).
- eng_wr_ena  out  3  x/y/m write enables to the engine.
- eng_wr_addr  out  ADDR_W  engine write address.
- eng_wr_x / eng_wr_y / eng_wr_m / eng_wr_m1  out  K each  engine write data.
- eng_task_req  out  1  engine task request.
- eng_task_grant  in  1  engine accepted task.
- eng_task_end  in  1  engine result word valid.
- eng_task_res  in  K  engine result word.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, counters 0. Reset mid-job aborts silently, with no done or err; the engine is reset by the same system reset.
- States: IDLE, LOAD, REQ, RES, DONE.
- IDLE, arbitration: the winner is the first asserted cli_req at index ptr, ptr+1, … mod R. Winner g is registered, and cli_gnt[g]=1 from the next cycle (enter LOAD, word counter wc=0). With no requests, stay in IDLE.
- LOAD, N cycles:
  - cli_addr=wc each cycle.
  - One cycle later the scheduler registers eng_wr_ena=3'b111, eng_wr_addr=wc and the client's x/y/m words.
  - wc increments and wraps N-1 to 0.
  - After the write of word N-1 is issued, go to REQ. The last write carries addr N-1, which triggers the engine's finish flag.
- eng_wr_m1 = cli_m1[g] combinationally while granted; 0 otherwise.
- REQ: eng_task_req=1, held until a cycle with eng_task_grant=1. That cycle drops req and enters RES with rc=0.
- RES:
  - Each cycle with eng_task_end=1, register cli_res=eng_task_res and cli_res_vld[g]=1 (1-cycle latency), then rc++.
  - Words arrive least significant first, and need not be contiguous.
  - After word N-1 is captured, go to DONE.
- DONE, 1 cycle: cli_done[g]=1; cli_gnt drops the following cycle; ptr=(g+1) mod R; return to IDLE. Earliest re-grant is the cycle after returning to IDLE.
- cli_req deasserted mid-job is ignored: the job completes.
- cli_req asserted by a non-granted client waits.
- eng_task_end outside RES is ignored.
- eng_task_grant outside REQ is ignored.
- cli_res_vld bits for non-granted clients are always 0.
- Fairness: with all R requesting continuously, grants rotate g=ptr, ptr+1, …

Optional Feature:
- Macro: IDDMM_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in REQ+RES.
  - On reaching TMO, pulse cli_err[g] for 1 cycle (no cli_done), drop eng_task_req, advance ptr and return to IDLE.
  - The counter clears on entering REQ.
- Undefined: no counter; cli_err tied 0; REQ/RES wait indefinitely.

Test Plan:
- N=4, R=4, only client 1 requests, x words 0x1..0x4: eng_wr_addr 0,1,2,3 with ena=3'b111 on 4 consecutive cycles; eng_task_req rises the cycle after the last write. The engine model returns 0xA0..0xA3: cli_res_vld[1] four times carrying 0xA0..0xA3, then a single cli_done[1].
- All 4 clients hold cli_req: grant order 0,1,2,3,0; cli_gnt never has two bits set.
- eng_task_grant delayed 10 cycles: eng_task_req is held high for exactly those cycles, then drops in the grant cycle.
- eng_task_end gapped (1,0,1,0,1,1): exactly 4 cli_res_vld pulses, in order; done after the 4th.
- rst asserted during LOAD word 2: all outputs 0 asynchronously; after release, a new request is granted starting at client 0 and loads from addr 0.
- With IDDMM_SCHED_TIMEOUT_EN, TMO=16, engine never grants: cli_err[g] pulses 16 cycles after entering REQ, no cli_done, busy falls, next requester is granted.
